dmem_arbiter: RTL and testbench

- Shares the single-port data memory block RAM between two requesters: port 0 (CPU load/store stage) and port 1 (program/data loader or debug DMA).
- Arbitrates requests, drives the BRAM enable/write/address/data pins, tracks the BRAM read latency, and returns read data with a one-cycle valid pulse to the requester that won.
- Sits between the datapath memory stage and the BRAM wrapper.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_rr_pick.sv | 40 ++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Arbitration policy selected by macro DMEM_ARB_RR_EN (see dmem_rr_pick).
package dmem_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int BYTE_OFF_W = 2;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker. DMEM_ARB_RR_EN defined: round-robin on contention;
// otherwise fixed priority with port 0 winning.
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       next_last
);

`ifdef DMEM_ARB_RR_EN
    logic contend_pick;
    // On contention favour the port that was not granted most recently.
    assign contend_pick = (last == PORT_CPU) ? PORT_DMA : PORT_CPU;
`else
    logic contend_pick;
    logic unused_last;
    assign contend_pick = PORT_CPU;
    assign unused_last  = last;
`endif

    always_comb begin
        gnt       = 2'b00;
        next_last = last;
        if (enable) begin
            case (reqs)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = contend_pick ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
            if (|gnt) begin
                next_last = gnt[1];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data BRAM and returns read data.
// Contention policy: round-robin when DMEM_ARB_RR_EN is defined, else port 0 priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              busy
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_nxt;
    logic [1:0]  lat_q, lat_nxt;
    logic        last_q, last_nxt;
    logic        rd_id_q, rd_mis_q;
    logic [1:0]  rvalid_q, err_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic [1:0]  gnt;
    logic        granted, win, win_we, win_mis, rd_done;
    logic [31:0] win_addr, win_wdata;
    logic        unused_hi;

    dmem_rr_pick u_pick (
        .reqs      ({p1_req, p0_req}),
        .last      (last_q),
        .enable    (reset && (state_q == IDLE)),
        .gnt       (gnt),
        .next_last (last_nxt)
    );

    assign granted   = |gnt;
    assign win       = gnt[1];
    assign win_we    = win ? p1_we    : p0_we;
    assign win_addr  = win ? p1_addr  : p0_addr;
    assign win_wdata = win ? p1_wdata : p0_wdata;
    assign win_mis   = |win_addr[BYTE_OFF_W-1:0];
    assign rd_done   = (state_q == RD_WAIT) && (lat_q == 2'd0);

    // Upper address bits wrap modulo the BRAM depth.
    assign unused_hi = ^{p0_addr[31:ADDR_W+BYTE_OFF_W], p1_addr[31:ADDR_W+BYTE_OFF_W]};

    assign mem_en   = granted;
    assign mem_we   = granted && win_we && !win_mis;
    assign mem_addr = granted ? win_addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W] : '0;
    assign mem_din  = granted ? win_wdata : '0;

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    // Write errors flag with the grant, read errors with the returned data.
    assign p0_err    = (gnt[0] && p0_we && (|p0_addr[BYTE_OFF_W-1:0])) || err_q[0];
    assign p1_err    = (gnt[1] && p1_we && (|p1_addr[BYTE_OFF_W-1:0])) || err_q[1];
    assign busy      = (state_q == RD_WAIT);

    always_comb begin
        state_nxt = state_q;
        lat_nxt   = lat_q;
        case (state_q)
            IDLE: begin
                if (granted && !win_we) begin
                    state_nxt = RD_WAIT;
                    lat_nxt   = LAT_INIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    lat_nxt = lat_q - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            lat_q    <= 2'd0;
            last_q   <= PORT_DMA;
            rd_id_q  <= PORT_CPU;
            rd_mis_q <= 1'b0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_nxt;
            lat_q    <= lat_nxt;
            last_q   <= last_nxt;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            if (granted && !win_we) begin
                rd_id_q  <= win;
                rd_mis_q <= win_mis;
            end
            if (rd_done) begin
                rvalid_q[rd_id_q] <= 1'b1;
                err_q[rd_id_q]    <= rd_mis_q;
                if (rd_id_q == PORT_DMA) begin
                    rdata1_q <= rd_mis_q ? 32'h0 : mem_dout;
                end else begin
                    rdata0_q <= rd_mis_q ? 32'h0 : mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level reference model.
// Follows DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [31:0]       p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din, mem_dout;

    dmem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    // BRAM with RD_LAT-cycle read pipeline
    logic [31:0] bram [DEPTH];
    logic [31:0] d1, d2;
    logic        bram_clr;
    always @(posedge clk) begin
        if (bram_clr) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            if (mem_en) begin
                if (mem_we) bram[mem_addr] <= mem_din;
                d1 <= bram[mem_addr];
            end
            d2 <= d1;
        end
    end
    assign mem_dout = (RD_LAT == 1) ? d1 : d2;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          last_p;
    bit          pend_v;
    int          pend_ret;
    bit          pend_port;
    logic [31:0] pend_data;
    bit          pend_err;
    bit   [1:0]  x_rvalid, x_err;
    logic [31:0] x_rdata [2];
    bit   [1:0]  seen_gnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model, advance the model, move to next negedge.
    task automatic step();
        bit [1:0]    r, g;
        bit          w, we, mis, mis0, mis1;
        logic [31:0] a, wd;
        int          idx;
        #1;
        r = {p1_req, p0_req};
        g = 2'b00;
        if (reset && !pend_v) begin
            if (r == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
                g = last_p ? 2'b01 : 2'b10;
`else
                g = 2'b01;
`endif
            end else begin
                g = r;
            end
        end
        w    = g[1];
        we   = w ? p1_we : p0_we;
        a    = w ? p1_addr : p0_addr;
        wd   = w ? p1_wdata : p0_wdata;
        mis  = (a[1:0] != 2'b00);
        idx  = int'(a[ADDR_W+1:2]);
        mis0 = (p0_addr[1:0] != 2'b00);
        mis1 = (p1_addr[1:0] != 2'b00);

        check_val("p0_gnt", 32'(p0_gnt), 32'(g[0]));
        check_val("p1_gnt", 32'(p1_gnt), 32'(g[1]));
        check_val("mem_en", 32'(mem_en), 32'(|g));
        check_val("busy", 32'(busy), 32'(pend_v));
        if (|g) begin
            check_val("mem_we", 32'(mem_we), 32'(we && !mis));
            check_val("mem_addr", 32'(mem_addr), 32'(idx));
            if (we) check_val("mem_din", mem_din, wd);
        end
        if (!reset) begin
            check_val("mem_we_rst", 32'(mem_we), 32'(0));
            check_val("mem_addr_rst", 32'(mem_addr), 32'(0));
        end
        check_val("p0_rvalid", 32'(p0_rvalid), 32'(x_rvalid[0]));
        check_val("p1_rvalid", 32'(p1_rvalid), 32'(x_rvalid[1]));
        check_val("p0_rdata", p0_rdata, x_rdata[0]);
        check_val("p1_rdata", p1_rdata, x_rdata[1]);
        check_val("p0_err", 32'(p0_err), 32'(x_err[0] | (g[0] & p0_we & mis0)));
        check_val("p1_err", 32'(p1_err), 32'(x_err[1] | (g[1] & p1_we & mis1)));
        seen_gnt = {p1_gnt, p0_gnt};

        if (!reset) begin
            pend_v     = 1'b0;
            last_p     = 1'b1;
            x_rvalid   = 2'b00;
            x_err      = 2'b00;
            x_rdata[0] = '0;
            x_rdata[1] = '0;
        end else begin
            x_rvalid = 2'b00;
            x_err    = 2'b00;
            if (pend_v && (cyc + 1 == pend_ret)) begin
                x_rvalid[pend_port] = 1'b1;
                x_err[pend_port]    = pend_err;
                x_rdata[pend_port]  = pend_data;
                pend_v              = 1'b0;
            end
            if (|g) begin
                last_p = w;
                if (we) begin
                    if (!mis) ref_mem[idx] = wd;
                end else begin
                    pend_v    = 1'b1;
                    pend_ret  = cyc + RD_LAT + 1;
                    pend_port = w;
                    pend_data = mis ? 32'h0 : ref_mem[idx];
                    pend_err  = mis;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_port(input bit p, input bit req, input bit we,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd;
        end
    endtask

    task automatic run_port(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd);
        set_port(p, 1'b1, we, a, wd);
        for (int k = 0; k < 40; k++) begin
            step();
            if (seen_gnt[p]) break;
        end
        check_val("grant_seen", 32'(seen_gnt[p]), 32'(1));
        if (p) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rand_req(input bit p);
        logic [31:0] a;
        a = ($urandom_range(0, 4) == 0) ? $urandom : (32'($urandom_range(0, 31)) << 2);
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        reset    = 1'b0;
        bram_clr = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_p = 1'b1; pend_v = 1'b0; pend_ret = 0; pend_port = 1'b0;
        pend_data = '0; pend_err = 1'b0;
        x_rvalid = 2'b00; x_err = 2'b00; x_rdata[0] = '0; x_rdata[1] = '0;
        seen_gnt = 2'b00;
        repeat (2) @(negedge clk);
        bram_clr = 1'b0;

        // reset state, with a request present that must not be granted
        p0_req = 1'b1;
        idle(2);
        p0_req = 1'b0;
        reset  = 1'b1;

        // write then read back
        run_port(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        run_port(1'b0, 1'b0, 32'h10, 32'h0);
        idle(4);

        // misaligned write suppressed, misaligned read returns 0 with err
        run_port(1'b0, 1'b1, 32'h13, 32'h12345678);
        run_port(1'b0, 1'b0, 32'h10, 32'h0);
        idle(4);
        run_port(1'b1, 1'b0, 32'h11, 32'h0);
        idle(4);

        // address wrap
        run_port(1'b0, 1'b1, 32'hFFFF_F004, 32'hCAFE0001);
        run_port(1'b1, 1'b0, 32'h4, 32'h0);
        idle(4);

        // contention: both read at once
        set_port(1'b0, 1'b1, 1'b0, 32'h0, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'h4, '0);
        for (int k = 0; k < 40 && (p0_req || p1_req); k++) begin
            step();
            if (seen_gnt[0]) p0_req = 1'b0;
            if (seen_gnt[1]) p1_req = 1'b0;
        end
        idle(4);

        // p0 keeps requesting; p1 starves unless round-robin
        set_port(1'b0, 1'b1, 1'b0, 32'h8, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'hC, '0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (seen_gnt[1]) p1_req = 1'b0;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        idle(4);

        // write from port 1 requested while a read is in flight
        set_port(1'b0, 1'b1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 10 && !seen_gnt[0]; k++) step();
        p0_req = 1'b0;
        run_port(1'b1, 1'b1, 32'h20, 32'h55AA55AA);
        idle(4);

        // reset the cycle after a read grant drops the read
        set_port(1'b0, 1'b1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 10 && !seen_gnt[0]; k++) step();
        p0_req = 1'b0;
        reset  = 1'b0;
        step();
        reset  = 1'b1;
        idle(6);
        run_port(1'b0, 1'b0, 32'h10, 32'h0);
        idle(4);

        // randomized traffic with occasional reset
        seen_gnt = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (seen_gnt[0]) p0_req = 1'b0;
            if (seen_gnt[1]) p1_req = 1'b0;
            if (!p0_req && $urandom_range(0, 2) == 0) rand_req(1'b0);
            if (!p1_req && $urandom_range(0, 2) == 0) rand_req(1'b1);
            step();
        end
        reset = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
